// File: rtl/rom_responder_if.sv
// Bus bundle between the CPU-side instruction bus / backing memory and the
// ROM responder. The slave modport is the ROM's view; master is the
// environment (CPU plus memory) view.
interface rom_responder_if;
  logic       sync;
  logic       cm_rom;
  logic [3:0] bus_in;
  logic [3:0] bus_out;
  logic       bus_out_enable;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic [7:0] mem_data;
  logic [2:0] phase;
  logic       synced;
  logic       sync_error;

  modport slave (
    input  sync, cm_rom, bus_in, mem_data,
    output bus_out, bus_out_enable, mem_addr, mem_read, phase, synced, sync_error
  );

  modport master (
    output sync, cm_rom, bus_in, mem_data,
    input  bus_out, bus_out_enable, mem_addr, mem_read, phase, synced, sync_error
  );
endinterface

// File: rtl/rom_responder.sv
// ROM endpoint of the 4-bit multiplexed instruction bus. Follows the
// 8-phase cycle (A1 A2 A3 M1 M2 X1 X2 X3) from SYNC, assembles the address
// over A1..A3, fetches the byte during A3 and returns OPR in M1, OPA in M2.
module rom_responder #(
  parameter logic [3:0] CHIP_ID      = 4'h0,
  parameter int         ADDR_LO_BITS = 8
) (
  input  logic          clock,
  input  logic          reset,
  rom_responder_if.slave bus
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X3 = 3'd7;

  logic [2:0]  phase_q;
  logic        synced_q;
  logic [11:0] addr_q;
  logic        selected_q;
  logic [3:0]  opa_q;
  logic        sync_error_q;

  logic        drive_ok;
  logic [ADDR_LO_BITS-1:0] byte_addr;

  // Phase tracking, SYNC checking, address capture and OPA holding register
  always_ff @(posedge clock) begin
    if (!reset) begin
      phase_q      <= PH_A1;
      synced_q     <= 1'b0;
      addr_q       <= 12'h000;
      selected_q   <= 1'b0;
      opa_q        <= 4'h0;
      sync_error_q <= 1'b0;
    end else begin
      sync_error_q <= 1'b0;

      // Phase counter: SYNC always forces A1; an expected X3 without SYNC drops lock
      if (bus.sync) begin
        phase_q  <= PH_A1;
        synced_q <= 1'b1;
        if (synced_q && phase_q != PH_X3) sync_error_q <= 1'b1;
      end else if (synced_q) begin
        if (phase_q == PH_X3) begin
          phase_q      <= PH_A1;
          synced_q     <= 1'b0;
          sync_error_q <= 1'b1;
        end else begin
          phase_q <= phase_q + 3'd1;
        end
      end else begin
        phase_q <= PH_A1;
      end

      if (synced_q) begin
        case (phase_q)
          PH_A1: addr_q[3:0] <= bus.bus_in;
          PH_A2: addr_q[7:4] <= bus.bus_in;
          PH_A3: begin
            addr_q[11:8] <= bus.bus_in;
            selected_q   <= (bus.bus_in == CHIP_ID) && bus.cm_rom;
          end
          PH_M1: if (selected_q) opa_q <= bus.mem_data[3:0];
          PH_M2: selected_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // The stored high nibble always equals CHIP_ID when selected is set; checking
  // it keeps the whole captured address part of the drive decision.
  assign drive_ok  = synced_q && selected_q && (addr_q[11:8] == CHIP_ID);
  assign byte_addr = addr_q[ADDR_LO_BITS-1:0];

  // Memory strobe and bus drive are combinational from the registered phase
  always_comb begin
    bus.mem_read       = synced_q && (phase_q == PH_A3);
    bus.mem_addr       = bus.mem_read ? byte_addr : 8'h00;
    bus.bus_out        = 4'h0;
    bus.bus_out_enable = 1'b0;
    if (drive_ok && phase_q == PH_M1) begin
      bus.bus_out        = bus.mem_data[7:4];
      bus.bus_out_enable = 1'b1;
    end else if (drive_ok && phase_q == PH_M2) begin
      bus.bus_out        = opa_q;
      bus.bus_out_enable = 1'b1;
    end
  end

  assign bus.phase      = phase_q;
  assign bus.synced     = synced_q;
  assign bus.sync_error = sync_error_q;

endmodule

// File: tb/tb_rom_responder.sv
// Bench for rom_responder: a cycle-level reference model plus directed bus
// cycles with literal expectations taken from hand-worked examples.
module tb_rom_responder;
  localparam logic [3:0] CHIP = 4'h0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  rom_responder_if rif();

  rom_responder #(.CHIP_ID(CHIP), .ADDR_LO_BITS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (rif.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] rom [256];

  // Backing memory: registered read; returns noise when not being read
  always @(posedge clock) begin
    if (rif.mem_read) rif.mem_data <= rom[rif.mem_addr];
    else              rif.mem_data <= 8'($urandom);
  end

  // Reference model: where in the bus cycle we are, and what address was sent
  int         m_phase  = 0;
  bit         m_synced = 0;
  bit         m_err    = 0;
  bit         m_sel    = 0;
  logic [3:0] m_nib [3];

  always @(posedge clock) begin
    if (!reset) begin
      m_phase = 0; m_synced = 0; m_err = 0; m_sel = 0;
      m_nib[0] = 0; m_nib[1] = 0; m_nib[2] = 0;
    end else begin
      int old_phase;
      bit old_synced;
      old_phase  = m_phase;
      old_synced = m_synced;
      if (old_synced && old_phase < 3) m_nib[old_phase] = rif.bus_in;
      if (old_synced && old_phase == 2) m_sel = (rif.bus_in == CHIP) && rif.cm_rom;
      if (old_synced && old_phase == 4) m_sel = 0;
      m_err = old_synced && (rif.sync ? (old_phase != 7) : (old_phase == 7));
      if (rif.sync)        begin m_phase = 0; m_synced = 1; end
      else if (!old_synced) m_phase = 0;
      else if (old_phase == 7) begin m_phase = 0; m_synced = 0; end
      else                 m_phase = old_phase + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle against the model, away from the active edge
  always @(negedge clock) begin
    logic [7:0] b;
    bit e_en, e_rd;
    int e_out;
    b     = rom[{m_nib[1], m_nib[0]}];
    e_rd  = m_synced && m_phase == 2;
    e_en  = m_synced && m_sel && (m_phase == 3 || m_phase == 4);
    e_out = !e_en ? 0 : (m_phase == 3 ? int'(b[7:4]) : int'(b[3:0]));
    chk("model_phase",   rif.phase, m_phase);
    chk("model_synced",  rif.synced, m_synced);
    chk("model_err",     rif.sync_error, m_err);
    chk("model_rd",      rif.mem_read, e_rd);
    chk("model_addr",    rif.mem_addr, e_rd ? {m_nib[1], m_nib[0]} : 0);
    chk("model_en",      rif.bus_out_enable, e_en);
    chk("model_out",     rif.bus_out, e_out);
  end

  task automatic step(input bit s, input bit cm, input logic [3:0] n);
    rif.sync = s; rif.cm_rom = cm; rif.bus_in = n;
    @(posedge clock); #1;
  endtask

  // Runs phases 0..last_p of a bus cycle; sync at last_p = last_sync.
  // Literal checks happen at the negedge inside each phase.
  task automatic run_cycle(input logic [3:0] n0, n1, n2, input bit cm,
                           input int last_p, input bit last_sync,
                           input logic [7:0] e_addr, input bit e_drive,
                           input logic [3:0] e_opr, e_opa, input string tag);
    for (int p = 0; p <= last_p; p++) begin
      rif.sync   = (p == last_p) ? last_sync : 1'b0;
      rif.cm_rom = (p == 2) ? cm : 1'b0;
      rif.bus_in = (p == 0) ? n0 : (p == 1) ? n1 : (p == 2) ? n2 : 4'($urandom);
      @(negedge clock);
      chk({tag, "_phase"}, rif.phase, p);
      if (p == 2) begin
        chk({tag, "_rd"}, rif.mem_read, 1);
        chk({tag, "_addr"}, rif.mem_addr, e_addr);
      end
      if (p == 3 || p == 4) begin
        chk({tag, "_en"}, rif.bus_out_enable, e_drive);
        if (e_drive) chk({tag, "_nib"}, rif.bus_out, p == 3 ? e_opr : e_opa);
      end else begin
        chk({tag, "_en_off"}, rif.bus_out_enable, 0);
      end
      @(posedge clock); #1;
    end
    $display("cycle %s addr=%02h drive=%0d", tag, e_addr, e_drive);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 37 + 11);
    rom[8'hA5] = 8'h3C;
    rom[8'h73] = 8'h9E;
    rom[8'h21] = 8'h5B;
    rif.sync = 0; rif.cm_rom = 0; rif.bus_in = 0; rif.mem_data = 0;

    reset = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_phase", rif.phase, 0);
    chk("rst_synced", rif.synced, 0);
    chk("rst_en", rif.bus_out_enable, 0);
    chk("rst_out", rif.bus_out, 0);
    chk("rst_rd", rif.mem_read, 0);
    chk("rst_addr", rif.mem_addr, 0);
    chk("rst_err", rif.sync_error, 0);
    $display("reset checked");
    @(posedge clock); #1;
    reset = 1;

    // Unsynced idle: phase stays 0
    repeat (4) step(0, 1, 4'h5);
    chk("idle_synced", rif.synced, 0);

    step(1, 0, 0);
    run_cycle(4'h5, 4'hA, 4'h0, 1, 7, 1, 8'hA5, 1, 4'h3, 4'hC, "hit");
    run_cycle(4'h5, 4'hA, 4'h1, 1, 7, 1, 8'hA5, 0, 4'h0, 4'h0, "wrongchip");
    run_cycle(4'h5, 4'hA, 4'h0, 0, 7, 1, 8'hA5, 0, 4'h0, 4'h0, "nocm");

    // Lost sync: no SYNC at X3
    run_cycle(4'h3, 4'h7, 4'h0, 1, 7, 0, 8'h73, 1, 4'h9, 4'hE, "lost");
    @(negedge clock);
    chk("lost_err", rif.sync_error, 1);
    chk("lost_synced", rif.synced, 0);
    chk("lost_phase", rif.phase, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("lost_err_once", rif.sync_error, 0);
    @(posedge clock); #1;
    repeat (10) step(0, 1, 4'h0);

    // Early sync during M2, then a normal fetch
    step(1, 0, 0);
    run_cycle(4'h5, 4'hA, 4'h0, 1, 4, 1, 8'hA5, 1, 4'h3, 4'hC, "early");
    @(negedge clock);
    chk("early_err", rif.sync_error, 1);
    chk("early_phase", rif.phase, 0);
    chk("early_synced", rif.synced, 1);
    @(posedge clock); #1;
    // Back at A1 immediately after the resync edge; step back one phase-slot
    run_cycle(4'h3, 4'h7, 4'h0, 1, 7, 1, 8'h73, 1, 4'h9, 4'hE, "after_early");

    // Reset asserted during M1 of a selected fetch
    run_cycle(4'h1, 4'h2, 4'h0, 1, 2, 0, 8'h21, 0, 4'h0, 4'h0, "pre_rst");
    rif.sync = 0; rif.cm_rom = 0; rif.bus_in = 0;
    @(negedge clock);
    chk("m1_en", rif.bus_out_enable, 1);
    chk("m1_opr", rif.bus_out, 4'h5);
    reset = 0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rstm1_en", rif.bus_out_enable, 0);
    chk("rstm1_synced", rif.synced, 0);
    chk("rstm1_phase", rif.phase, 0);
    @(posedge clock); #1;
    reset = 1;
    repeat (10) step(0, 1, 4'h0);
    chk("post_rst_synced", rif.synced, 0);
    $display("reset during M1 checked");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rom_responder.md
Name: rom_responder

Overview:
- ROM-side endpoint of the 4-bit multiplexed instruction bus; the CPU's PC stack is the other end.
- Tracks the 8-phase bus cycle from SYNC (A1 A2 A3 M1 M2 X1 X2 X3).
- Captures the 12-bit address nibble-by-nibble during A1–A3 and decides chip select from the A3 nibble plus CM-ROM.
- Fetches the byte from a synchronous-read memory and drives OPR in M1 and OPA in M2.

Parameters:
- CHIP_ID, 4'h0, value of address bits [11:8] that selects this ROM.
- ADDR_LO_BITS, 8, width of the in-chip byte address (fixed at 8; parameter kept for lint/readability only).

Ports:
- clock  input  1  system clock, all state on posedge.
- reset  input  1  synchronous reset, active-low.
- sync  input  1  high during X3; the next cycle is A1.
- cm_rom  input  1  ROM command/select strobe, sampled in A3.
- bus_in  input  4  data bus as driven by the CPU.
- bus_out  output  4  nibble driven onto the bus by this ROM.
- bus_out_enable  output  1  high when bus_out is valid and should be driven.
- mem_addr  output  8  byte address to backing memory.
- mem_read  output  1  read strobe to backing memory.
- mem_data  input  8  read data, valid the cycle after mem_read.
- phase  output  3  current phase, 0=A1 … 7=X3.
- synced  output  1  phase tracking locked.
- sync_error  output  1  one-cycle pulse on a SYNC protocol violation.

Behaviour:
- Reset (reset==0 at posedge) clears:
  - phase=0, synced=0, addr=12'h000, selected=0, opa_latch=0.
  - All outputs read 0: bus_out=0, bus_out_enable=0, mem_read=0, mem_addr=0, sync_error=0.
- Reset mid-operation: the next edge aborts any drive. The block stays unsynced until the next sync.
- Phase counter:
  - sync high at an edge → phase<=0 (A1) and synced<=1.
  - Otherwise, if synced, phase<=phase+1, wrapping 7→0.
  - Unsynced and sync low → phase holds 0.
- sync_error is registered and pulses high for one cycle when either:
  - synced, phase==7 and sync low (lost sync): synced<=0, phase<=0; or
  - synced, phase!=7 and sync high (early sync): still resync to A1.
- Address capture, all gated by synced:
  - A1 (phase 0): addr[3:0]<=bus_in.
  - A2 (phase 1): addr[7:4]<=bus_in.
  - A3 (phase 2): addr[11:8]<=bus_in, and selected<=(bus_in==CHIP_ID)&&cm_rom.
- Memory fetch:
  - mem_read is high combinationally in phase 2 when synced.
  - mem_addr={addr[7:4],addr[3:0]}; both nibbles are already latched in A3.
  - mem_data is valid in phase 3.
  - mem_addr is 0 whenever mem_read is low.
- Drive:
  - M1 (phase 3) and selected: bus_out=mem_data[7:4], bus_out_enable=1, opa_latch<=mem_data[3:0] at the end of M1.
  - M2 (phase 4) and selected: bus_out=opa_latch, bus_out_enable=1.
  - All other phases, or not selected: bus_out=0, bus_out_enable=0.
  - selected clears at the end of phase 4.
- Latency: address complete at the end of A3; OPR is on the bus in the first cycle after A3.
- Address wrap is not this block's concern: the 12-bit address comes from the CPU. An address with high nibble != CHIP_ID is ignored entirely (no drive).
- No bus contention: bus_out_enable is never high outside phases 3–4.

Test Plan:
- Pulse sync, then drive nibbles 4'h5, 4'hA, CHIP_ID(0) with cm_rom=1 in A3; memory returns 8'h3C → mem_addr=8'hA5 and mem_read in A3; bus_out=4'h3 with enable in M1; bus_out=4'hC with enable in M2; enable low in X1–X3.
- Same sequence with A3 nibble 4'h1 (≠ CHIP_ID) → mem_read still pulses; bus_out_enable stays 0 for all 8 phases.
- Correct address, cm_rom=0 in A3 → no drive.
- Hold sync low at phase 7 → sync_error pulses once, synced=0, no further drive until the next sync.
- Assert sync at phase 4 → sync_error pulse, next phase=0, and the subsequent fetch works normally.
- Assert reset (low) during M1 of a selected fetch → next cycle bus_out_enable=0, synced=0, phase=0. After release, nothing is driven until sync.
